// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding, baud divider and parity helpers.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;

  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * 16);
    return (d < 1) ? 1 : d;
  endfunction

  // Payload is zero-extended to 9 bits; the extra zeros leave the XOR unchanged.
  function automatic logic par_bit(input logic [8:0] d, input int mode);
    return (mode == PAR_EVEN) ? ^d : (mode == PAR_ODD) ? ~(^d) : 1'b0;
  endfunction
endpackage

// File: rtl/uart_param_core_if.sv
// Host-side bundle of the UART core: transmit handshake, serial lines and receive results.
interface uart_param_core_if #(parameter int DATA_BITS = 8);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_done;
  logic                 tx;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (output tx_valid, tx_data, rx,
                  input  tx_ready, tx_done, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err);
  modport slave  (input  tx_valid, tx_data, rx,
                  output tx_ready, tx_done, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err);
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversample tick shared by the transmitter and receiver.
module uart_baud_gen import uart_pkg::*; #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                  cnt <= '0;
    else if (cnt == CW'(DIV-1))  cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CW'(DIV-1));
endmodule

// File: rtl/uart_param_core.sv
// Parameterised full-duplex UART: independent TX and RX FSMs on one 16x oversample tick.
module uart_param_core import uart_pkg::*; #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst_n,
  uart_param_core_if.slave bus
);
  logic tick;

  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_baud (.clk(clk), .rst_n(rst_n), .tick(tick));

  uart_state_e          ts, ts_n;
  logic                 tgo, tgo_n, tpar, tpar_n, tx_q, tx_n, tdone;
  logic [3:0]           tcnt, tcnt_n, tidx, tidx_n;
  logic [DATA_BITS-1:0] tsh, tsh_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts <= ST_IDLE; tgo <= 1'b0; tpar <= 1'b0; tcnt <= '0; tidx <= '0; tsh <= '0; tx_q <= 1'b1;
    end else begin
      ts <= ts_n; tgo <= tgo_n; tpar <= tpar_n; tcnt <= tcnt_n; tidx <= tidx_n; tsh <= tsh_n; tx_q <= tx_n;
    end
  end

  // tgo marks that the first tick after acceptance has passed and the start bit is on the line.
  // The last stop bit ends one tick early so a held tx_valid yields gap-free frames.
  always_comb begin
    ts_n = ts; tgo_n = tgo; tpar_n = tpar; tcnt_n = tcnt; tidx_n = tidx; tsh_n = tsh;
    tdone = 1'b0;
    case (ts)
      ST_IDLE: if (bus.tx_valid) begin
        ts_n = ST_START; tgo_n = 1'b0; tsh_n = bus.tx_data; tpar_n = par_bit(9'(bus.tx_data), PARITY);
      end
      ST_START: if (tick) begin
        if (!tgo)               begin tgo_n = 1'b1; tcnt_n = '0; end
        else if (tcnt == 4'd15) begin ts_n = ST_DATA; tcnt_n = '0; tidx_n = '0; end
        else                    tcnt_n = tcnt + 4'd1;
      end
      ST_DATA: if (tick) begin
        if (tcnt == 4'd15) begin
          tcnt_n = '0; tsh_n = tsh >> 1;
          if (tidx == 4'(DATA_BITS-1)) begin
            tidx_n = '0; ts_n = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else tidx_n = tidx + 4'd1;
        end else tcnt_n = tcnt + 4'd1;
      end
      ST_PARITY: if (tick) begin
        if (tcnt == 4'd15) begin ts_n = ST_STOP; tcnt_n = '0; tidx_n = '0; end
        else               tcnt_n = tcnt + 4'd1;
      end
      ST_STOP: if (tick) begin
        if (tidx == 4'(STOP_BITS-1) && tcnt == 4'd14) begin ts_n = ST_IDLE; tdone = 1'b1; end
        else if (tcnt == 4'd15) begin tcnt_n = '0; tidx_n = tidx + 4'd1; end
        else tcnt_n = tcnt + 4'd1;
      end
      default: ts_n = ST_IDLE;
    endcase
    case (ts_n)
      ST_START:  tx_n = ~tgo_n;
      ST_DATA:   tx_n = tsh_n[0];
      ST_PARITY: tx_n = tpar_n;
      default:   tx_n = 1'b1;
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = (ts == ST_IDLE);
  assign bus.tx_done  = tdone & rst_n;

  uart_state_e          rs, rs_n;
  logic                 rs1, rs2, rprev, rpar, rpar_n, rload;
  logic                 rvalid, rperr, rferr;
  logic [3:0]           rcnt, rcnt_n, ridx, ridx_n;
  logic [DATA_BITS-1:0] rsh, rsh_n, rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1 <= 1'b1; rs2 <= 1'b1; rprev <= 1'b1;
      rs <= ST_IDLE; rcnt <= '0; ridx <= '0; rsh <= '0; rpar <= 1'b0;
      rdata <= '0; rvalid <= 1'b0; rperr <= 1'b0; rferr <= 1'b0;
    end else begin
      rs1 <= bus.rx; rs2 <= rs1; rprev <= rs2;
      rs <= rs_n; rcnt <= rcnt_n; ridx <= ridx_n; rsh <= rsh_n; rpar <= rpar_n;
      rvalid <= rload;
      if (rload) begin
        rdata <= rsh;
        rperr <= (PARITY != PAR_NONE) && (rpar != par_bit(9'(rsh), PARITY));
        rferr <= ~rs2;
      end
    end
  end

  // rprev must be high to leave IDLE, so a line stuck low after a break cannot re-trigger.
  always_comb begin
    rs_n = rs; rcnt_n = rcnt; ridx_n = ridx; rsh_n = rsh; rpar_n = rpar;
    rload = 1'b0;
    case (rs)
      ST_IDLE: if (rprev && !rs2) begin rs_n = ST_START; rcnt_n = '0; end
      ST_START: if (tick) begin
        if (rcnt == 4'd7) begin rcnt_n = '0; ridx_n = '0; rs_n = rs2 ? ST_IDLE : ST_DATA; end
        else              rcnt_n = rcnt + 4'd1;
      end
      ST_DATA: if (tick) begin
        if (rcnt == 4'd15) begin
          rcnt_n = '0; rsh_n = {rs2, rsh[DATA_BITS-1:1]};
          if (ridx == 4'(DATA_BITS-1)) rs_n = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          else                         ridx_n = ridx + 4'd1;
        end else rcnt_n = rcnt + 4'd1;
      end
      ST_PARITY: if (tick) begin
        if (rcnt == 4'd15) begin rcnt_n = '0; rpar_n = rs2; rs_n = ST_STOP; end
        else               rcnt_n = rcnt + 4'd1;
      end
      ST_STOP: if (tick) begin
        if (rcnt == 4'd15) begin rload = 1'b1; rs_n = ST_IDLE; end
        else               rcnt_n = rcnt + 4'd1;
      end
      default: rs_n = ST_IDLE;
    endcase
  end

  assign bus.rx_data       = rdata;
  assign bus.rx_valid      = rvalid;
  assign bus.rx_parity_err = rperr;
  assign bus.rx_frame_err  = rferr;
endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: three instances (8N1, 8E1, 8O1) at DIV=10, tx looped to rx or driven.
module tb_uart_param_core;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] tv, sel, drv, txl, trdy, tdone, rvl, pe, fe;
  logic [7:0] td [3];
  logic [7:0] rd [3];

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int PM = (g == 0) ? 0 : (g == 1) ? 2 : 1;
    uart_param_core_if #(.DATA_BITS(8)) bus ();
    assign bus.tx_valid = tv[g];
    assign bus.tx_data  = td[g];
    assign bus.rx       = sel[g] ? drv[g] : bus.tx;
    assign txl[g]  = bus.tx;
    assign trdy[g] = bus.tx_ready;
    assign tdone[g] = bus.tx_done;
    assign rvl[g]  = bus.rx_valid;
    assign pe[g]   = bus.rx_parity_err;
    assign fe[g]   = bus.rx_frame_err;
    assign rd[g]   = bus.rx_data;
    uart_param_core #(.CLK_FREQ(1600000), .BAUD(10000), .DATA_BITS(8), .PARITY(PM), .STOP_BITS(1))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  end

  typedef struct packed { logic [1:0] g; logic pe; logic fe; logic [7:0] d; } exp_t;
  exp_t expq [$];
  int total = 0, bad = 0;
  int rx_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Line image of a frame, bit 0 first: start, payload LSB first, optional parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input int pm, input logic stop,
                                             input logic pflip);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (pm == 0) f[9] = stop;
    else begin
      f[9]  = ((pm == 2) ? ^d : ~(^d)) ^ pflip;
      f[10] = stop;
    end
    return f;
  endfunction

  // Scoreboard: each received frame must match the oldest expectation for that instance.
  always @(negedge clk) begin
    int k;
    if (rst_n) begin
      for (int g = 0; g < 3; g++) begin
        if (tdone[g]) done_cnt[g]++;
        if (rvl[g]) begin
          rx_cnt[g]++;
          k = -1;
          for (int i = 0; i < expq.size(); i++) if (k < 0 && int'(expq[i].g) == g) k = i;
          if (k < 0) begin
            total++; bad++;
            $display("FAIL rx_unexpected dut%0d: got data=%h pe=%b fe=%b want no frame", g, rd[g], pe[g], fe[g]);
          end else begin
            chk($sformatf("rx_frame_dut%0d", g), {22'd0, pe[g], fe[g], rd[g]},
                {22'd0, expq[k].pe, expq[k].fe, expq[k].d});
            expq.delete(k);
          end
        end
      end
    end
  end

  task automatic expect_rx(input int g, input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e.g = 2'(g); e.d = d; e.pe = p; e.fe = f;
    expq.push_back(e);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (expq.size() != 0 && t < 400) begin @(negedge clk); t++; end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL rx_missing: got %0d outstanding want 0", expq.size());
      expq.delete();
    end
  endtask

  task automatic wait_ready(input int g);
    int t = 0;
    while (!trdy[g] && t < 3000) begin @(negedge clk); t++; end
    if (!trdy[g]) begin total++; bad++; $display("FAIL tx_ready_timeout dut%0d: got 0 want 1", g); end
  endtask

  task automatic send(input int g, input logic [7:0] d, output int acc);
    td[g] = d;
    tv[g] = 1'b1;
    wait_ready(g);
    acc = cyc;
    @(negedge clk);
    tv[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output int dc);
    int t = 0;
    while (!tdone[g] && t < 2000) begin @(negedge clk); t++; end
    dc = cyc;
    if (!tdone[g]) begin
      total++; bad++;
      $display("FAIL tx_done_timeout dut%0d: got 0 want 1", g);
      dc = -100000;
    end
    @(negedge clk);
  endtask

  task automatic line_check(input int g, input logic [7:0] d, input int pm, output logic pb);
    logic [10:0] fb;
    int n, t;
    fb = frame_bits(d, pm, 1'b1, 1'b0);
    n = (pm == 0) ? 10 : 11;
    pb = 1'bx;
    t = 0;
    while (txl[g] !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    if (txl[g] !== 1'b0) begin
      total++; bad++;
      $display("FAIL start_timeout dut%0d: got 1 want 0", g);
      return;
    end
    repeat (80) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (160) @(negedge clk);
      chk($sformatf("line_dut%0d_bit%0d", g, i), {31'd0, txl[g]}, {31'd0, fb[i]});
      if (pm != 0 && i == 9) pb = txl[g];
    end
  endtask

  task automatic loop_test(input int g, input logic [7:0] d, input int pm, output logic pb);
    int acc, dc, base;
    base = (pm == 0) ? 1600 : 1760;
    expect_rx(g, d, 1'b0, 1'b0);
    fork
      line_check(g, d, pm, pb);
      begin
        send(g, d, acc);
        wait_done(g, dc);
        chk_rng($sformatf("tx_done_latency_dut%0d", g), dc - acc, base - 10, base + 10);
      end
    join
    wait_drain();
  endtask

  task automatic drive_frame(input int g, input logic [10:0] fb, input int n);
    drv[g] = 1'b1;
    sel[g] = 1'b1;
    for (int i = 0; i < n; i++) begin
      drv[g] = fb[i];
      repeat (160) @(negedge clk);
    end
    drv[g] = 1'b1;
    repeat (320) @(negedge clk);
    sel[g] = 1'b0;
  endtask

  initial begin
    logic pb;
    int dcy [3];
    int acc, dc0, rc0;
    logic [7:0] w [3];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    tv = '0; sel = '0; drv = '1;
    for (int g = 0; g < 3; g++) td[g] = '0;

    // Model pins: hand-built line images.
    chk("model_8n1_a5", {21'd0, frame_bits(8'hA5, 0, 1'b1, 1'b0)}, 32'h74A);
    chk("model_8e1_07", {21'd0, frame_bits(8'h07, 2, 1'b1, 1'b0)}, 32'h60E);
    chk("model_8o1_07", {21'd0, frame_bits(8'h07, 1, 1'b1, 1'b0)}, 32'h40E);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_tx%0d", g),       {31'd0, txl[g]},   32'd1);
      chk($sformatf("rst_ready%0d", g),    {31'd0, trdy[g]},  32'd1);
      chk($sformatf("rst_done%0d", g),     {31'd0, tdone[g]}, 32'd0);
      chk($sformatf("rst_rxvalid%0d", g),  {31'd0, rvl[g]},   32'd0);
      chk($sformatf("rst_rxdata%0d", g),   {24'd0, rd[g]},    32'd0);
      chk($sformatf("rst_perr%0d", g),     {31'd0, pe[g]},    32'd0);
      chk($sformatf("rst_ferr%0d", g),     {31'd0, fe[g]},    32'd0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    loop_test(0, 8'hA5, 0, pb);
    loop_test(1, 8'h07, 2, pb);
    chk("line_parity_8e1_07", {31'd0, pb}, 32'd1);
    loop_test(2, 8'h07, 1, pb);
    chk("line_parity_8o1_07", {31'd0, pb}, 32'd0);

    expect_rx(1, 8'h07, 1'b1, 1'b0);
    drive_frame(1, frame_bits(8'h07, 2, 1'b1, 1'b1), 11);
    wait_drain();

    expect_rx(0, 8'h3C, 1'b0, 1'b1);
    drive_frame(0, frame_bits(8'h3C, 0, 1'b0, 1'b0), 10);
    wait_drain();

    rc0 = rx_cnt[0];
    sel[0] = 1'b1;
    drv[0] = 1'b0;
    repeat (30) @(negedge clk);
    drv[0] = 1'b1;
    repeat (400) @(negedge clk);
    sel[0] = 1'b0;
    chk("glitch_no_rx", rx_cnt[0], rc0);

    for (int k = 0; k < 3; k++) expect_rx(0, w[k], 1'b0, 1'b0);
    td[0] = w[0];
    tv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready(0);
      @(negedge clk);
      if (k < 2) td[0] = w[k+1];
      wait_done(0, dcy[k]);
      if (k == 2) tv[0] = 1'b0;
    end
    chk("b2b_gap_01", dcy[1] - dcy[0], 1600);
    chk("b2b_gap_12", dcy[2] - dcy[1], 1600);
    wait_drain();
    repeat (200) @(negedge clk);

    dc0 = done_cnt[0];
    rc0 = rx_cnt[0];
    send(0, 8'hC3, acc);
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tx_high",  {31'd0, txl[0]},  32'd1);
    chk("abort_tx_ready", {31'd0, trdy[0]}, 32'd1);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    chk("abort_no_done", done_cnt[0], dc0);
    chk("abort_no_rx",   rx_cnt[0],   rc0);
    loop_test(0, 8'h5A, 0, pb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
